// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the two-way write-back cache:
//   - state_t    : controller state encoding
//   - calc_off_w : byte-offset width of one cache line
//   - calc_idx_w : set-index width
//   - calc_tag_w : tag width left over after index and offset
// -----------------------------------------------------------------------------
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_COMPARE    = 3'd1,
      ST_WRITE_BACK = 3'd2,
      ST_ALLOCATE   = 3'd3,
      ST_REFILL     = 3'd4
   } state_t;

   function automatic int calc_off_w(input int word_w, input int line_words);
      return $clog2(line_words * word_w / 8);
   endfunction

   function automatic int calc_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int calc_tag_w(input int addr_w, input int idx_w, input int off_w);
      return addr_w - idx_w - off_w;
   endfunction

endpackage

// File: rtl/cache_way.sv
// -----------------------------------------------------------------------------
// cache_way
// Storage for one way of the cache: per-set valid, dirty, tag and line.
// Reads are asynchronous at 'idx'; a write stores tag/line/dirty and marks
// the entry valid. Only valid/dirty are cleared by reset.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   idx                   set index (read and write)
//   wr_en                 write strobe
//   wr_tag/wr_line        tag and line to store
//   wr_dirty              dirty flag to store
//   rd_valid/rd_dirty     status of the addressed entry
//   rd_tag/rd_line        contents of the addressed entry
// -----------------------------------------------------------------------------
module cache_way #(
   parameter int IDX_W  = 8,
   parameter int TAG_W  = 20,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  idx,
   input  logic              wr_en,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              wr_dirty,
   output logic              rd_valid,
   output logic              rd_dirty,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line
);

   localparam int SETS = 1 << IDX_W;

   logic [SETS-1:0]   valid_r;
   logic [SETS-1:0]   dirty_r;
   logic [TAG_W-1:0]  tag_r  [SETS];
   logic [LINE_W-1:0] line_r [SETS];

   // status bits: cleared on reset so the whole way reads as empty
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_r <= {SETS{1'b0}};
         dirty_r <= {SETS{1'b0}};
      end else if (wr_en) begin
         valid_r[idx] <= 1'b1;
         dirty_r[idx] <= wr_dirty;
      end
   end

   // tag and data arrays: contents are meaningless until valid is set
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_r[idx]  <= wr_tag;
         line_r[idx] <= wr_line;
      end
   end

   assign rd_valid = valid_r[idx];
   assign rd_dirty = dirty_r[idx];
   assign rd_tag   = tag_r[idx];
   assign rd_line  = line_r[idx];

endmodule

// File: rtl/wb_cache_2way.sv
// -----------------------------------------------------------------------------
// wb_cache_2way
// Two-way set-associative, write-back, write-allocate cache with one LRU bit
// per set and saturating hit/miss counters.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   cpu_req_valid/ready/rw/addr/wdata  CPU request (ready only while idle)
//   cpu_rsp_valid/rdata                one-cycle completion, read data
//   mem_req_valid/ready/rw/addr/wdata  line-granular memory request
//   mem_rsp_valid/rdata                refill line return
//   hit_cnt, miss_cnt                  saturating statistics
// -----------------------------------------------------------------------------
module wb_cache_2way
   import cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cpu_req_valid,
   output logic                         cpu_req_ready,
   input  logic                         cpu_req_rw,
   input  logic [ADDR_W-1:0]            cpu_req_addr,
   input  logic [WORD_W-1:0]            cpu_req_wdata,
   output logic                         cpu_rsp_valid,
   output logic [WORD_W-1:0]            cpu_rsp_rdata,
   output logic                         mem_req_valid,
   input  logic                         mem_req_ready,
   output logic                         mem_req_rw,
   output logic [ADDR_W-1:0]            mem_req_addr,
   output logic [WORD_W*LINE_WORDS-1:0] mem_req_wdata,
   input  logic                         mem_rsp_valid,
   input  logic [WORD_W*LINE_WORDS-1:0] mem_rsp_rdata,
   output logic [31:0]                  hit_cnt,
   output logic [31:0]                  miss_cnt
);

   localparam int LINE_W = WORD_W * LINE_WORDS;
   localparam int OFF_W  = calc_off_w(WORD_W, LINE_WORDS);
   localparam int IDX_W  = calc_idx_w(SETS);
   localparam int TAG_W  = calc_tag_w(ADDR_W, IDX_W, OFF_W);
   localparam int BYTE_W = $clog2(WORD_W / 8);
   localparam int WSEL_W = $clog2(LINE_WORDS);

   state_t              state_r;
   logic                ready_r, rsp_valid_r, mem_valid_r, mem_rw_r;
   logic [WORD_W-1:0]   rdata_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [LINE_W-1:0]   mem_wdata_r;
   logic [31:0]         hit_cnt_r, miss_cnt_r;
   logic [SETS-1:0]     lru_r;
   logic                req_rw_r, refilled_r, victim_r;
   logic [TAG_W-1:0]    req_tag_r;
   logic [IDX_W-1:0]    req_idx_r;
   logic [WSEL_W-1:0]   req_wsel_r;
   logic [WORD_W-1:0]   req_wdata_r;

   logic [1:0]          rd_valid_s, rd_dirty_s, wr_en_s;
   logic [TAG_W-1:0]    rd_tag_s  [2];
   logic [LINE_W-1:0]   rd_line_s [2];
   logic [LINE_W-1:0]   wr_line_s, hit_line_s, merged_line_s;
   logic                wr_dirty_s, hit0_s, hit1_s, any_hit_s, hit_way_s;
   logic                victim_s, vic_dirty_s;
   logic [WORD_W-1:0]   hit_word_s;

   for (genvar w = 0; w < 2; w++) begin : g_way
      cache_way #(.IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W)) u_way (
         .clk      (clk),
         .rst_n    (rst_n),
         .idx      (req_idx_r),
         .wr_en    (wr_en_s[w]),
         .wr_tag   (req_tag_r),
         .wr_line  (wr_line_s),
         .wr_dirty (wr_dirty_s),
         .rd_valid (rd_valid_s[w]),
         .rd_dirty (rd_dirty_s[w]),
         .rd_tag   (rd_tag_s[w]),
         .rd_line  (rd_line_s[w])
      );
   end

   if (BYTE_W > 0) begin : g_byte_unused
      logic unused_byte_s;
      assign unused_byte_s = ^cpu_req_addr[BYTE_W-1:0];
   end

   // tag compare, word select/merge and victim choice for the latched request
   always_comb begin
      hit0_s        = rd_valid_s[0] && (rd_tag_s[0] == req_tag_r);
      // way0 takes priority should both ways ever hold the same tag
      hit1_s        = rd_valid_s[1] && (rd_tag_s[1] == req_tag_r) && !hit0_s;
      any_hit_s     = hit0_s || hit1_s;
      hit_way_s     = hit1_s;
      hit_line_s    = hit_way_s ? rd_line_s[1] : rd_line_s[0];
      hit_word_s    = hit_line_s[req_wsel_r*WORD_W +: WORD_W];
      merged_line_s = hit_line_s;
      merged_line_s[req_wsel_r*WORD_W +: WORD_W] = req_wdata_r;
      // empty ways are filled first (way0 before way1), then LRU decides
      if (!rd_valid_s[0]) begin
         victim_s = 1'b0;
      end else if (!rd_valid_s[1]) begin
         victim_s = 1'b1;
      end else begin
         victim_s = lru_r[req_idx_r];
      end
      vic_dirty_s = rd_valid_s[victim_s] && rd_dirty_s[victim_s];
   end

   // way write control: write-hit merge in COMPARE, line fill in REFILL
   always_comb begin
      wr_en_s    = 2'b00;
      wr_line_s  = mem_rsp_rdata;
      wr_dirty_s = 1'b0;
      case (state_r)
         ST_COMPARE: begin
            if (any_hit_s && req_rw_r) begin
               wr_en_s[hit_way_s] = 1'b1;
               wr_line_s          = merged_line_s;
               wr_dirty_s         = 1'b1;
            end else begin
               wr_en_s = 2'b00;
            end
         end
         ST_REFILL: begin
            if (mem_rsp_valid) begin
               wr_en_s[victim_r] = 1'b1;
            end else begin
               wr_en_s = 2'b00;
            end
         end
         default: begin
            wr_en_s = 2'b00;
         end
      endcase
   end

   // controller FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         rdata_r     <= {WORD_W{1'b0}};
         mem_valid_r <= 1'b0;
         mem_rw_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {LINE_W{1'b0}};
         hit_cnt_r   <= 32'd0;
         miss_cnt_r  <= 32'd0;
         lru_r       <= {SETS{1'b0}};
         req_rw_r    <= 1'b0;
         refilled_r  <= 1'b0;
         victim_r    <= 1'b0;
         req_tag_r   <= {TAG_W{1'b0}};
         req_idx_r   <= {IDX_W{1'b0}};
         req_wsel_r  <= {WSEL_W{1'b0}};
         req_wdata_r <= {WORD_W{1'b0}};
      end else begin
         rsp_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cpu_req_valid && ready_r) begin
                  req_rw_r    <= cpu_req_rw;
                  req_tag_r   <= cpu_req_addr[ADDR_W-1 -: TAG_W];
                  req_idx_r   <= cpu_req_addr[OFF_W +: IDX_W];
                  req_wsel_r  <= cpu_req_addr[BYTE_W +: WSEL_W];
                  req_wdata_r <= cpu_req_wdata;
                  refilled_r  <= 1'b0;
                  ready_r     <= 1'b0;
                  state_r     <= ST_COMPARE;
               end
            end
            ST_COMPARE: begin
               if (any_hit_s) begin
                  rsp_valid_r         <= 1'b1;
                  rdata_r             <= req_rw_r ? {WORD_W{1'b0}} : hit_word_s;
                  lru_r[req_idx_r]    <= ~hit_way_s;
                  // the compare that follows a refill is not a real hit
                  if (!refilled_r && (hit_cnt_r != 32'hFFFF_FFFF)) begin
                     hit_cnt_r <= hit_cnt_r + 32'd1;
                  end
                  ready_r <= 1'b1;
                  state_r <= ST_IDLE;
               end else begin
                  if (miss_cnt_r != 32'hFFFF_FFFF) begin
                     miss_cnt_r <= miss_cnt_r + 32'd1;
                  end
                  victim_r    <= victim_s;
                  mem_valid_r <= 1'b1;
                  if (vic_dirty_s) begin
                     mem_rw_r    <= 1'b1;
                     mem_addr_r  <= {rd_tag_s[victim_s], req_idx_r, {OFF_W{1'b0}}};
                     mem_wdata_r <= rd_line_s[victim_s];
                     state_r     <= ST_WRITE_BACK;
                  end else begin
                     mem_rw_r    <= 1'b0;
                     mem_addr_r  <= {req_tag_r, req_idx_r, {OFF_W{1'b0}}};
                     mem_wdata_r <= {LINE_W{1'b0}};
                     state_r     <= ST_ALLOCATE;
                  end
               end
            end
            ST_WRITE_BACK: begin
               // request stays up: the fetch follows the eviction directly
               if (mem_req_ready) begin
                  mem_rw_r    <= 1'b0;
                  mem_addr_r  <= {req_tag_r, req_idx_r, {OFF_W{1'b0}}};
                  mem_wdata_r <= {LINE_W{1'b0}};
                  state_r     <= ST_ALLOCATE;
               end
            end
            ST_ALLOCATE: begin
               if (mem_req_ready) begin
                  mem_valid_r <= 1'b0;
                  mem_addr_r  <= {ADDR_W{1'b0}};
                  state_r     <= ST_REFILL;
               end
            end
            ST_REFILL: begin
               if (mem_rsp_valid) begin
                  refilled_r <= 1'b1;
                  state_r    <= ST_COMPARE;
               end
            end
            default: begin
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign cpu_req_ready = ready_r;
   assign cpu_rsp_valid = rsp_valid_r;
   assign cpu_rsp_rdata = rdata_r;
   assign mem_req_valid = mem_valid_r;
   assign mem_req_rw    = mem_rw_r;
   assign mem_req_addr  = mem_addr_r;
   assign mem_req_wdata = mem_wdata_r;
   assign hit_cnt       = hit_cnt_r;
   assign miss_cnt      = miss_cnt_r;

endmodule
